// File: rtl/wave_gen_pkg.sv
// Shared encodings for the waveform generator: waveform select, ramp direction
// and the accumulator peak helper.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI    = 2'd0,
        WAVE_SAW_UP = 2'd1,
        WAVE_SAW_DN = 2'd2,
        WAVE_SQUARE = 2'd3
    } wave_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int SHIFT_W = 4;

    // Largest positive value of a signed acc_w-bit accumulator.
    function automatic int peak_of(input int acc_w);
        return (1 << (acc_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/wave_gen_if.sv
// Control/sample bundle between a waveform consumer (master) and wave_gen (slave).
interface wave_gen_if #(
    parameter int OUT_W = 16
);
    logic             enable;
    logic [1:0]       mode;
    logic [3:0]       shift_by;
    logic             sync;
    logic [OUT_W-1:0] out;
    logic             cycle_start;

    modport master (
        output enable, mode, shift_by, sync,
        input  out, cycle_start
    );

    modport slave (
        input  enable, mode, shift_by, sync,
        output out, cycle_start
    );
endinterface

// File: rtl/wave_phase_acc.sv
// Clamped phase accumulator: saturated step, triangle up/down ramp or sawtooth
// reset-to-zero, and a wrap flag on every return to phase 0.
module wave_phase_acc
    import wave_gen_pkg::*;
#(
    parameter int ACC_W     = 26,
    parameter int BASE_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    input  logic               tri_mode,
    input  logic [SHIFT_W-1:0] shift_by,
    output logic [ACC_W-1:0]   ctr,
    output logic               wrap
);

    localparam int               WIDE_W = ACC_W + 16;
    localparam logic [ACC_W-1:0] PEAK   = ACC_W'(peak_of(ACC_W));

    logic [WIDE_W-1:0] step_wide;
    logic [ACC_W-1:0]  step;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  ctr_nxt;
    logic              wrap_nxt;
    dir_t              state, state_nxt;

    // Shift at full width so large shift_by values saturate instead of wrapping.
    always_comb begin
        step_wide = WIDE_W'(BASE_STEP) << shift_by;
        step      = (step_wide > WIDE_W'(PEAK)) ? PEAK : step_wide[ACC_W-1:0];
        sum       = {1'b0, ctr} + {1'b0, step};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr   <= '0;
            state <= DIR_UP;
            wrap  <= 1'b0;
        end else begin
            ctr   <= ctr_nxt;
            state <= state_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        ctr_nxt   = ctr;
        state_nxt = state;
        wrap_nxt  = 1'b0;
        if (restart) begin
            ctr_nxt   = '0;
            state_nxt = DIR_UP;
            wrap_nxt  = 1'b1;
        end else if (enable) begin
            if (tri_mode) begin
                if (state == DIR_UP) begin
                    if (sum >= {1'b0, PEAK}) begin
                        ctr_nxt   = PEAK;
                        state_nxt = DIR_DOWN;
                    end else begin
                        ctr_nxt = sum[ACC_W-1:0];
                    end
                end else if (ctr <= step) begin
                    ctr_nxt   = '0;
                    state_nxt = DIR_UP;
                    wrap_nxt  = 1'b1;
                end else begin
                    ctr_nxt = ctr - step;
                end
            end else begin
                state_nxt = DIR_UP;
                if (sum > {1'b0, PEAK}) begin
                    ctr_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    ctr_nxt = sum[ACC_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/wave_gen.sv
// Waveform generator top: mode tracking, phase accumulator and registered
// sample/cycle_start outputs, one cycle behind the accumulator.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int ACC_W     = 26,
    parameter int OUT_W     = 16,
    parameter int BASE_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    wave_gen_if.slave  bus
);

    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (ACC_W - 2);

    wave_mode_t       mode_in, mode_q;
    logic             mode_chg;
    logic             restart;
    logic [ACC_W-1:0] ctr;
    logic             wrap;
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] out_d;

    assign mode_in  = wave_mode_t'(bus.mode);
    assign mode_chg = bus.enable && (mode_in != mode_q);
    assign restart  = bus.sync || mode_chg;

    wave_phase_acc #(
        .ACC_W     (ACC_W),
        .BASE_STEP (BASE_STEP)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .enable   (bus.enable),
        .restart  (restart),
        .tri_mode (mode_q == WAVE_TRI),
        .shift_by (bus.shift_by),
        .ctr      (ctr),
        .wrap     (wrap)
    );

    // mode_q only moves on cycles that act on it, so a change made while
    // disabled still triggers the restart on the next enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode_q <= WAVE_TRI;
        else if (bus.sync || bus.enable)
            mode_q <= mode_in;
    end

    assign r = ctr[ACC_W-2 -: OUT_W];

    always_comb begin
        out_d = r;
        case (mode_q)
            WAVE_TRI,
            WAVE_SAW_UP: out_d = r;
            WAVE_SAW_DN: out_d = ~r;
            WAVE_SQUARE: out_d = (ctr >= HALF) ? '1 : '0;
            default:     out_d = r;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out         <= '0;
            bus.cycle_start <= 1'b0;
        end else begin
            bus.out         <= out_d;
            bus.cycle_start <= wrap;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Directed + randomized bench for wave_gen at ACC_W=10, OUT_W=8, BASE_STEP=4.
module tb_wave_gen;

    localparam int ACC_W     = 10;
    localparam int OUT_W     = 8;
    localparam int BASE_STEP = 4;
    localparam int PEAK      = 511;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wave_gen_if #(.OUT_W(OUT_W)) bus ();

    wave_gen #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .BASE_STEP (BASE_STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: phase value, ramp direction, latched mode,
    // pending restart flag, and the expected registered outputs.
    int m_ctr, m_down, m_mode, m_wrap;
    int e_out, e_cs;
    int cyc;
    int cs_q[$];
    int out_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sample(input int c, input int md);
        int rr;
        rr = (c / 2) % 256;
        case (md)
            2:       return 255 - rr;
            3:       return (c >= 256) ? 255 : 0;
            default: return rr;
        endcase
    endfunction

    task automatic model_reset();
        m_ctr = 0; m_down = 0; m_mode = 0; m_wrap = 0;
        e_out = 0; e_cs = 0;
    endtask

    task automatic model_edge();
        int st, nctr, ndown, nwrap;
        st    = BASE_STEP * (1 << bus.shift_by);
        if (st > PEAK) st = PEAK;
        nctr  = m_ctr;
        ndown = m_down;
        nwrap = 0;
        e_out = sample(m_ctr, m_mode);
        e_cs  = m_wrap;
        if (bus.sync || (bus.enable && int'(bus.mode) != m_mode)) begin
            nctr = 0; ndown = 0; nwrap = 1;
        end else if (bus.enable) begin
            if (m_mode == 0) begin
                if (!m_down) begin
                    if (m_ctr + st >= PEAK) begin nctr = PEAK; ndown = 1; end
                    else nctr = m_ctr + st;
                end else if (m_ctr <= st) begin
                    nctr = 0; ndown = 0; nwrap = 1;
                end else begin
                    nctr = m_ctr - st;
                end
            end else begin
                ndown = 0;
                if (m_ctr + st > PEAK) begin nctr = 0; nwrap = 1; end
                else nctr = m_ctr + st;
            end
        end
        if (bus.sync || bus.enable) m_mode = int'(bus.mode);
        m_ctr = nctr; m_down = ndown; m_wrap = nwrap;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("out", bus.out, e_out);
        check("cycle_start", bus.cycle_start, e_cs);
        if (bus.cycle_start === 1'b1) cs_q.push_back(cyc);
        out_hist.push_back(int'(bus.out));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_hist();
        cs_q.delete();
        out_hist.delete();
        cyc = 0;
    endtask

    initial begin
        int mx, p;
        cyc = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.mode     = 2'd0;
        bus.shift_by = 4'd0;
        bus.sync     = 1'b0;
        model_reset();
        #12;
        check("reset_out", bus.out, 0);
        check("reset_cs", bus.cycle_start, 0);
        @(negedge clk);
        reset = 1'b0;

        // Triangle, shift 0: 256-cycle period, peak sample 255.
        bus.enable = 1'b1;
        clear_hist();
        run(600);
        mx = 0;
        foreach (out_hist[i]) if (out_hist[i] > mx) mx = out_hist[i];
        check("tri_peak", mx, 255);
        check("tri_pulses", cs_q.size(), 2);
        if (cs_q.size() >= 2) check("tri_period", cs_q[1] - cs_q[0], 256);

        // Saw up, shift 2: 32-cycle period.
        bus.mode = 2'd1; bus.shift_by = 4'd2;
        clear_hist();
        run(100);
        check("saw_pulses", cs_q.size(), 4);
        if (cs_q.size() >= 4) begin
            check("saw_period_a", cs_q[1] - cs_q[0], 32);
            check("saw_period_b", cs_q[3] - cs_q[2], 32);
        end

        // Square, shift 0: 64 low then 64 high.
        bus.mode = 2'd3; bus.shift_by = 4'd0;
        clear_hist();
        run(300);
        check("sq_restart_pulse", cs_q.size() > 0, 1);
        if (cs_q.size() > 0) begin
            p = cs_q[0] - 1;
            check("sq_lo_first", out_hist[p], 0);
            check("sq_lo_last", out_hist[p+63], 0);
            check("sq_hi_first", out_hist[p+64], 255);
            check("sq_hi_last", out_hist[p+127], 255);
            check("sq_wrap", out_hist[p+128], 0);
        end

        // Triangle with saturated step: 0 / 255 alternation.
        bus.mode = 2'd0; bus.shift_by = 4'd9;
        clear_hist();
        run(12);
        if (cs_q.size() > 0) begin
            p = cs_q[0] - 1;
            check("sat_a", out_hist[p], 0);
            check("sat_b", out_hist[p+1], 255);
            check("sat_c", out_hist[p+2], 0);
            check("sat_pulse_gap", cs_q[1] - cs_q[0], 2);
        end else begin
            check("sat_pulse_seen", 0, 1);
        end

        // Mid-ramp saw up -> saw down.
        bus.mode = 2'd1; bus.shift_by = 4'd0;
        run(40);
        bus.mode = 2'd2;
        tick();
        tick();
        check("mode_chg_cs", bus.cycle_start, 1);
        check("mode_chg_out", bus.out, 255);

        // Async reset mid-cycle, hold while disabled, sync while disabled.
        run(10);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_out", bus.out, 0);
        check("async_rst_cs", bus.cycle_start, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.enable = 1'b0;
        clear_hist();
        run(20);
        mx = 0;
        foreach (out_hist[i]) if (out_hist[i] != 0) mx++;
        check("disabled_hold", mx, 0);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        tick();
        check("sync_disabled_cs", bus.cycle_start, 1);
        run(5);
        bus.enable = 1'b1;
        run(20);

        // Randomized mix against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.enable = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 4)  bus.mode     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5)  bus.shift_by = 4'($urandom_range(0, 10));
            bus.sync = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
